// File: rtl/pwm_carr_bank_writer_if.sv
// Write port of the carrier bank writer: one channel carrier plus mask bit per
// valid/ready transfer, addressed by channel index.
`ifndef PWM_WIDTH
`define PWM_WIDTH 8
`endif
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

interface pwm_carr_bank_writer_if #(
  parameter int N_CH = `PWM_WIDTH,
  parameter int CW   = `PWMCOUNT_WIDTH,
  parameter int SELW = $clog2(N_CH)
);
  logic            wr_valid;
  logic            wr_ready;
  logic [SELW-1:0] wr_sel;
  logic [CW-1:0]   wr_carr;
  logic            wr_mask;

  modport master (output wr_valid, wr_sel, wr_carr, wr_mask, input wr_ready);
  modport slave  (input wr_valid, wr_sel, wr_carr, wr_mask, output wr_ready);
endinterface

// File: rtl/pwm_carr_bank_writer.sv
// Shadow/active carrier bank writer: writes collect in a shadow bank and are
// committed to the active bank as a whole on the first sync after update_req.
`ifndef PWM_WIDTH
`define PWM_WIDTH 8
`endif
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module pwm_carr_bank_lane #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [CW-1:0] carr_i,
  input  logic          mask_i,
  input  logic          commit_i,
  output logic [CW-1:0] carr_o,
  output logic          mask_o
);
  logic [CW-1:0] shd_carr_q, act_carr_q;
  logic          shd_mask_q, act_mask_q;

  // Write (IDLE) and commit (ARMED) never coincide, so order is irrelevant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd_carr_q <= '0;
      shd_mask_q <= 1'b0;
      act_carr_q <= '0;
      act_mask_q <= 1'b0;
    end else begin
      if (wr_en_i) begin
        shd_carr_q <= carr_i;
        shd_mask_q <= mask_i;
      end
      if (commit_i) begin
        act_carr_q <= shd_carr_q;
        act_mask_q <= shd_mask_q;
      end
    end
  end

  assign carr_o = act_carr_q;
  assign mask_o = act_mask_q;
endmodule

module pwm_carr_bank_writer #(
  parameter int N_CH = `PWM_WIDTH,
  parameter int CW   = `PWMCOUNT_WIDTH,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pwm_carr_bank_writer_if.slave    wr,
  input  logic                     update_req_i,
  input  logic                     sync_i,
  input  logic                     err_clr_i,
  output logic [N_CH*CW-1:0]       out_carr_o,
  output logic [N_CH-1:0]          out_mask_o,
  output logic                     pending_o,
  output logic                     upd_done_o,
  output logic                     wr_err_o
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ARMED = 1'b1;

  logic [0:0] state_q, state_d;
  logic       rdy_q, rdy_d;
  logic       upd_done_q, wr_err_q, wr_err_d;
  logic       accept, in_range, commit;
  logic [N_CH-1:0]          lane_wr;
  logic [N_CH-1:0][CW-1:0]  act_carr;
  logic [N_CH-1:0]          act_mask;

  assign accept   = wr.wr_valid && rdy_q;
  assign in_range = ({1'b0, wr.wr_sel} < (SELW+1)'(N_CH));
  assign commit   = (state_q == S_ARMED) && sync_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (update_req_i) state_d = S_ARMED;
      S_ARMED: if (sync_i)       state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Ready mirrors the next state so it is a pure register, and stays low in reset.
  assign rdy_d = (state_d == S_IDLE);

  always_comb begin
    wr_err_d = wr_err_q;
    if (err_clr_i)            wr_err_d = 1'b0;
    if (accept && !in_range)  wr_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rdy_q      <= 1'b0;
      upd_done_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      upd_done_q <= commit;
      wr_err_q   <= wr_err_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    assign lane_wr[k] = accept && in_range && (wr.wr_sel == SELW'(k));

    pwm_carr_bank_lane #(.CW(CW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en_i  (lane_wr[k]),
      .carr_i   (wr.wr_carr),
      .mask_i   (wr.wr_mask),
      .commit_i (commit),
      .carr_o   (act_carr[k]),
      .mask_o   (act_mask[k])
    );
  end

  assign wr.wr_ready = rdy_q;
  assign out_carr_o  = act_carr;
  assign out_mask_o  = act_mask;
  assign pending_o   = (state_q == S_ARMED);
  assign upd_done_o  = upd_done_q;
  assign wr_err_o    = wr_err_q;
endmodule

// File: tb/tb_pwm_carr_bank_writer.sv
// Directed bench: a vector table for reset and the basic commit, then
// hand-written sequences for stall, simultaneous request, reset mid-ARMED and
// out-of-range writes on a 6-channel build.
module tb_pwm_carr_bank_writer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;

  // 8-channel build
  logic         rst8 = 1'b0, upd8 = 1'b0, syn8 = 1'b0, clr8 = 1'b0;
  logic [127:0] carr8;
  logic [7:0]   mask8;
  logic         pend8, done8, err8;
  pwm_carr_bank_writer_if #(.N_CH(8), .CW(16), .SELW(3)) bus8 ();

  pwm_carr_bank_writer #(.N_CH(8), .CW(16), .SELW(3)) dut8 (
    .clk(clk), .rst_n(rst8), .wr(bus8.slave), .update_req_i(upd8), .sync_i(syn8),
    .err_clr_i(clr8), .out_carr_o(carr8), .out_mask_o(mask8), .pending_o(pend8),
    .upd_done_o(done8), .wr_err_o(err8)
  );

  // 6-channel build for out-of-range selects
  logic         rst6 = 1'b0, upd6 = 1'b0, syn6 = 1'b0, clr6 = 1'b0;
  logic [95:0]  carr6;
  logic [5:0]   mask6;
  logic         pend6, done6, err6;
  pwm_carr_bank_writer_if #(.N_CH(6), .CW(16), .SELW(3)) bus6 ();

  pwm_carr_bank_writer #(.N_CH(6), .CW(16), .SELW(3)) dut6 (
    .clk(clk), .rst_n(rst6), .wr(bus6.slave), .update_req_i(upd6), .sync_i(syn6),
    .err_clr_i(clr6), .out_carr_o(carr6), .out_mask_o(mask6), .pending_o(pend6),
    .upd_done_o(done6), .wr_err_o(err6)
  );

  typedef struct {
    logic         rst_n, vld;
    logic [2:0]   sel;
    logic [15:0]  carr;
    logic         msk, upd, syn;
    logic         e_rdy, e_pend, e_done;
    logic [127:0] e_carr;
    logic [7:0]   e_mask;
  } vec_t;

  localparam logic [127:0] C1 = {16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h0, 16'h0, 16'h0};
  localparam logic [127:0] C2 = C1 | 128'h0001;
  localparam logic [127:0] C3 = C2 | (128'h00AA << 16);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv8(input logic rst, vld, input logic [2:0] sel, input logic [15:0] c,
                      input logic m, upd, syn);
    rst8 = rst; bus8.wr_valid = vld; bus8.wr_sel = sel; bus8.wr_carr = c;
    bus8.wr_mask = m; upd8 = upd; syn8 = syn;
  endtask

  task automatic drv6(input logic rst, vld, input logic [2:0] sel, input logic [15:0] c,
                      input logic m, upd, syn, clr);
    rst6 = rst; bus6.wr_valid = vld; bus6.wr_sel = sel; bus6.wr_carr = c;
    bus6.wr_mask = m; upd6 = upd; syn6 = syn; clr6 = clr;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk8(input string nm, input logic rdy, pend, done,
                      input logic [127:0] c, input logic [7:0] m);
    chk({nm, ".rdy"},  {127'b0, bus8.wr_ready}, {127'b0, rdy});
    chk({nm, ".pend"}, {127'b0, pend8}, {127'b0, pend});
    chk({nm, ".done"}, {127'b0, done8}, {127'b0, done});
    chk({nm, ".carr"}, carr8, c);
    chk({nm, ".mask"}, {120'b0, mask8}, {120'b0, m});
  endtask

  vec_t tbl[13];

  initial begin
    //            rst vld sel carr     m  upd syn  rdy pend done carr mask
    tbl[0]  = '{1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 3'd3, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0, 8'h00};
    tbl[5]  = '{1'b1, 1'b1, 3'd7, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 8'h00};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 8'h00};
    tbl[11] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, C1,     8'h08};
    tbl[12] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C1,     8'h08};

    drv6(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset and basic commit
    for (int i = 0; i < 13; i++) begin
      drv8(tbl[i].rst_n, tbl[i].vld, tbl[i].sel, tbl[i].carr, tbl[i].msk, tbl[i].upd, tbl[i].syn);
      tick();
      chk8($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_pend, tbl[i].e_done,
           tbl[i].e_carr, tbl[i].e_mask);
    end
    chk("err8_idle", {127'b0, err8}, 128'h0);

    // stall: ready held low in ARMED, write lands in the cycle after the commit
    drv8(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drv8(1'b1, 1'b1, 3'd0, 16'h0001, 1'b0, 1'b0, 1'b0); tick();
      chk8($sformatf("stall%0d", i), 1'b0, 1'b1, 1'b0, C1, 8'h08);
    end
    drv8(1'b1, 1'b1, 3'd0, 16'h0001, 1'b0, 1'b0, 1'b1); tick();
    chk8("stall_commit", 1'b1, 1'b0, 1'b1, C1, 8'h08);
    drv8(1'b1, 1'b1, 3'd0, 16'h0001, 1'b0, 1'b0, 1'b0); tick();
    chk8("stall_accept", 1'b1, 1'b0, 1'b0, C1, 8'h08);
    drv8(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0); tick();
    drv8(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
    chk8("stall_recommit", 1'b1, 1'b0, 1'b1, C2, 8'h08);

    // write + update_req + sync together: armed, no commit yet
    drv8(1'b1, 1'b1, 3'd1, 16'h00AA, 1'b0, 1'b1, 1'b1); tick();
    chk8("simul_nocommit", 1'b0, 1'b1, 1'b0, C2, 8'h08);
    drv8(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
    chk8("simul_commit", 1'b1, 1'b0, 1'b1, C3, 8'h08);

    // reset while ARMED abandons the commit and clears both banks
    drv8(1'b1, 1'b1, 3'd2, 16'h5555, 1'b1, 1'b0, 1'b0); tick();
    drv8(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0); tick();
    chk8("rst_armed_pre", 1'b0, 1'b1, 1'b0, C3, 8'h08);
    drv8(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0); tick();
    chk8("rst_armed", 1'b0, 1'b0, 1'b0, 128'h0, 8'h00);
    drv8(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
    chk8("rst_idle_sync", 1'b1, 1'b0, 1'b0, 128'h0, 8'h00);
    drv8(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0); tick();
    drv8(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
    chk8("rst_zero_commit", 1'b1, 1'b0, 1'b1, 128'h0, 8'h00);
    drv8(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);

    // out-of-range writes on the 6-channel build
    drv6(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drv6(1'b1, 1'b1, 3'd2, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drv6(1'b1, 1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("oor_ready", {127'b0, bus6.wr_ready}, 128'h1);
    tick();
    chk("oor_err_set", {127'b0, err6}, 128'h1);
    chk("oor_ready_after", {127'b0, bus6.wr_ready}, 128'h1);
    drv6(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drv6(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("oor_done", {127'b0, done6}, 128'h1);
    chk("oor_carr", {32'b0, carr6}, 128'h7777 << 32);
    chk("oor_mask", {122'b0, mask6}, 128'h04);
    drv6(1'b1, 1'b1, 3'd6, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    chk("oor_clr_vs_set", {127'b0, err6}, 128'h1);
    drv6(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk("oor_clr", {127'b0, err6}, 128'h0);
    drv6(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drv6(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("oor_recommit", {32'b0, carr6}, 128'h7777 << 32);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
